// File: rtl/priority_sequencer.sv
// Picks the frontmost opaque layer (and, with SECOND_TARGET_EN defined, the runner-up)
// by scanning the OBJ and BG0..BG3 candidates one slot per cycle.
module priority_sequencer #(
    parameter logic [2:0] BACKDROP_ID = 3'd5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0][19:0] cand,
    input  logic [4:0]       mask,
    input  logic [4:0]       opaque,
    input  logic [14:0]      backdrop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      top_color,
    output logic [2:0]       top_layer
`ifdef SECOND_TARGET_EN
    ,
    output logic [14:0]      second_color,
    output logic [2:0]       second_layer
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [2:0] SENTINEL  = 3'b100;
    localparam logic [2:0] SLOT_END  = 3'd5;

    state_t           state;
    logic [2:0]       slot;
    logic [4:0]       elig_q;
    logic [4:0][1:0]  prio_q;
    logic [4:0][14:0] color_q;

    logic [2:0]       best_prio;
    logic [14:0]      best_color;
    logic [2:0]       best_layer;
`ifdef SECOND_TARGET_EN
    logic [2:0]       sec_prio;
    logic [14:0]      sec_color;
    logic [2:0]       sec_layer;
`endif

    logic             accept;
    logic             cur_elig;
    logic [1:0]       cur_prio;
    logic [14:0]      cur_color;
    logic [2:0]       cur_layer;
    logic             reserved_unused;

    // The sentinel (bit 2 set) loses to every real 2-bit priority; ties keep the incumbent.
    function automatic logic beats(input logic [1:0] p, input logic [2:0] incumbent);
        return incumbent[2] || (p < incumbent[1:0]);
    endfunction

    function automatic logic [2:0] layer_of(input logic [2:0] s);
        return (s == 3'd0) ? 3'd4 : s - 3'd1;
    endfunction

    assign accept          = in_valid && in_ready;
    assign reserved_unused = ^{cand[0][17:15], cand[1][17:15], cand[2][17:15],
                               cand[3][17:15], cand[4][17:15]};

    always_comb begin
        cur_elig  = 1'b0;
        cur_prio  = 2'd0;
        cur_color = 15'h0000;
        for (int i = 0; i < 5; i++) begin
            if (slot == i[2:0]) begin
                cur_elig  = elig_q[i];
                cur_prio  = prio_q[i];
                cur_color = color_q[i];
            end
        end
        cur_layer = layer_of(slot);
    end

    // Candidate set is pure data: captured on a transfer, never reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            elig_q <= mask & opaque;
            for (int i = 0; i < 5; i++) begin
                prio_q[i]  <= cand[i][19:18];
                color_q[i] <= cand[i][14:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= 3'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            best_prio  <= SENTINEL;
            best_color <= 15'h0000;
            best_layer <= BACKDROP_ID;
`ifdef SECOND_TARGET_EN
            sec_prio   <= SENTINEL;
            sec_color  <= 15'h0000;
            sec_layer  <= BACKDROP_ID;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= SCAN;
                        in_ready   <= 1'b0;
                        slot       <= 3'd0;
                        best_prio  <= SENTINEL;
                        best_color <= backdrop;
                        best_layer <= BACKDROP_ID;
`ifdef SECOND_TARGET_EN
                        sec_prio   <= SENTINEL;
                        sec_color  <= backdrop;
                        sec_layer  <= BACKDROP_ID;
`endif
                    end
                end
                SCAN: begin
                    // Slots 0..4 take one cycle each; the extra cycle at SLOT_END enters DONE.
                    if (slot == SLOT_END) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        slot <= slot + 3'd1;
                        if (cur_elig) begin
                            if (beats(cur_prio, best_prio)) begin
`ifdef SECOND_TARGET_EN
                                sec_prio  <= best_prio;
                                sec_color <= best_color;
                                sec_layer <= best_layer;
`endif
                                best_prio  <= {1'b0, cur_prio};
                                best_color <= cur_color;
                                best_layer <= cur_layer;
                            end
`ifdef SECOND_TARGET_EN
                            else if (beats(cur_prio, sec_prio)) begin
                                sec_prio  <= {1'b0, cur_prio};
                                sec_color <= cur_color;
                                sec_layer <= cur_layer;
                            end
`endif
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        slot      <= 3'd0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign top_color = best_color;
    assign top_layer = best_layer;
`ifdef SECOND_TARGET_EN
    assign second_color = sec_color;
    assign second_layer = sec_layer;
`endif

endmodule

// File: tb/tb_priority_sequencer.sv
// Bench for priority_sequencer: fixed vectors, handshake/reset corner sequences and
// randomized sets checked against a sort-style reference model.
module tb_priority_sequencer;
    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0][19:0] cand;
    logic [4:0]       mask;
    logic [4:0]       opaque;
    logic [14:0]      backdrop;
    logic             out_valid;
    logic             out_ready;
    logic [14:0]      top_color;
    logic [2:0]       top_layer;
`ifdef SECOND_TARGET_EN
    logic [14:0]      second_color;
    logic [2:0]       second_layer;
`endif

    priority_sequencer #(.BACKDROP_ID(3'd5)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cand(cand),
        .mask(mask),
        .opaque(opaque),
        .backdrop(backdrop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .top_color(top_color),
        .top_layer(top_layer)
`ifdef SECOND_TARGET_EN
        ,
        .second_color(second_color),
        .second_layer(second_layer)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  m;
        logic [4:0]  o;
        logic [9:0]  p;   // {BG3,BG2,BG1,BG0,OBJ}, 2 bits each
        logic [14:0] bg;
        logic [2:0]  tl;
        logic [14:0] tc;
        logic [2:0]  sl;
        logic [14:0] sc;
    } vec_t;

    vec_t             tbl [8];
    logic [4:0][14:0] cur_col;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] slot_layer(input int s);
        return (s < 0) ? 3'd5 : ((s == 0) ? 3'd4 : 3'(s - 1));
    endfunction

    // Top = eligible slot with smallest (priority, scan position); second = next smallest.
    function automatic void model(input logic [4:0] el, input logic [9:0] p, input logic [14:0] bg,
                                  output logic [2:0] tl, output logic [14:0] tc,
                                  output logic [2:0] sl, output logic [14:0] sc);
        int key [5];
        int first;
        int nxt;
        first = -1;
        nxt   = -1;
        for (int i = 0; i < 5; i++) key[i] = el[i] ? int'(p[2*i +: 2]) * 8 + i : 1000;
        for (int i = 0; i < 5; i++)
            if (key[i] < 1000 && (first < 0 || key[i] < key[first])) first = i;
        for (int i = 0; i < 5; i++)
            if (i != first && key[i] < 1000 && (nxt < 0 || key[i] < key[nxt])) nxt = i;
        tl = slot_layer(first);
        tc = (first < 0) ? bg : cur_col[first];
        sl = slot_layer(nxt);
        sc = (nxt < 0) ? bg : cur_col[nxt];
    endfunction

    task automatic drive_set(input logic [4:0] m, input logic [4:0] o, input logic [9:0] p,
                             input logic [14:0] bg);
        for (int i = 0; i < 5; i++) cand[i] = {p[2*i +: 2], 3'($urandom), cur_col[i]};
        mask     = m;
        opaque   = o;
        backdrop = bg;
        in_valid = 1'b1;
    endtask

    task automatic transfer(input logic [4:0] m, input logic [4:0] o, input logic [9:0] p,
                            input logic [14:0] bg);
        @(negedge clock);
        chk("in_ready_idle", in_ready, 1);
        drive_set(m, o, p, bg);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input logic [2:0] tl, input logic [14:0] tc,
                                input logic [2:0] sl, input logic [14:0] sc);
        chk("top_layer", top_layer, tl);
        chk("top_color", top_color, tc);
`ifdef SECOND_TARGET_EN
        chk("second_layer", second_layer, sl);
        chk("second_color", second_color, sc);
`else
        if (sl === 3'bx && sc === 15'bx) $display("note: second target undefined");
`endif
    endtask

    task automatic release_result(input int hold);
        repeat (hold) begin
            @(posedge clock);
            #1;
            chk("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("ret_in_ready", in_ready, 1);
        chk("ret_out_valid", out_valid, 0);
    endtask

    initial begin
        int          lat;
        logic        saw;
        logic [4:0]  rm;
        logic [4:0]  ro;
        logic [9:0]  rp;
        logic [14:0] rbg;
        logic [2:0]  etl;
        logic [14:0] etc_;
        logic [2:0]  esl;
        logic [14:0] esc;

        cur_col = {15'h4321, 15'h1234, 15'h7C00, 15'h03E0, 15'h001F};
        tbl[0] = '{5'h1F, 5'h1F, {2'd1, 2'd0, 2'd3, 2'd1, 2'd2}, 15'h0000, 3'd2, 15'h1234, 3'd0, 15'h03E0};
        tbl[1] = '{5'h1F, 5'h1F, {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, 15'h0000, 3'd4, 15'h001F, 3'd0, 15'h03E0};
        tbl[2] = '{5'h00, 5'h1F, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 15'h7C1F, 3'd5, 15'h7C1F, 3'd5, 15'h7C1F};
        tbl[3] = '{5'h1F, 5'h00, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 15'h0555, 3'd5, 15'h0555, 3'd5, 15'h0555};
        tbl[4] = '{5'h1F, 5'h10, {2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 15'h0AAA, 3'd3, 15'h4321, 3'd5, 15'h0AAA};
        tbl[5] = '{5'h1F, 5'h1F, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 15'h0000, 3'd4, 15'h001F, 3'd0, 15'h03E0};
        tbl[6] = '{5'h1F, 5'h1F, {2'd0, 2'd2, 2'd2, 2'd3, 2'd3}, 15'h0000, 3'd3, 15'h4321, 3'd1, 15'h7C00};
        tbl[7] = '{5'h1E, 5'h1F, {2'd2, 2'd1, 2'd1, 2'd2, 2'd0}, 15'h0000, 3'd1, 15'h7C00, 3'd2, 15'h1234};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cand      = '0;
        mask      = 5'h00;
        opaque    = 5'h00;
        backdrop  = 15'h0000;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_top_color", top_color, 15'h0000);
        chk("rst_top_layer", top_layer, 3'd5);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            transfer(tbl[v].m, tbl[v].o, tbl[v].p, tbl[v].bg);
            wait_done(lat);
            chk("latency", lat, 6);
            check_result(tbl[v].tl, tbl[v].tc, tbl[v].sl, tbl[v].sc);
            release_result(v % 3);
        end

        // Backpressure: result must hold while in_valid toggles with another set.
        transfer(tbl[0].m, tbl[0].o, tbl[0].p, tbl[0].bg);
        wait_done(lat);
        chk("bp_latency", lat, 6);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            drive_set(tbl[1].m, tbl[1].o, tbl[1].p, tbl[1].bg);
            in_valid = c[0];
            @(posedge clock);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            check_result(tbl[0].tl, tbl[0].tc, tbl[0].sl, tbl[0].sc);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("bp_ret_in_ready", in_ready, 1);
        chk("bp_ret_out_valid", out_valid, 0);

        // Reset in the middle of a scan discards the set.
        transfer(tbl[5].m, tbl[5].o, tbl[5].p, tbl[5].bg);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_top_color", top_color, 15'h0000);
        chk("mid_rst_top_layer", top_layer, 3'd5);
        #2;
        reset = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            saw = saw | out_valid;
        end
        chk("mid_rst_no_valid", saw, 0);
        transfer(tbl[7].m, tbl[7].o, tbl[7].p, tbl[7].bg);
        wait_done(lat);
        chk("post_rst_latency", lat, 6);
        check_result(tbl[7].tl, tbl[7].tc, tbl[7].sl, tbl[7].sc);
        release_result(0);

        // Randomized sets against the reference model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 5; i++) cur_col[i] = 15'($urandom);
            rm  = 5'($urandom);
            ro  = 5'($urandom);
            rp  = 10'($urandom);
            rbg = 15'($urandom);
            model(rm & ro, rp, rbg, etl, etc_, esl, esc);
            transfer(rm, ro, rp, rbg);
            wait_done(lat);
            chk("rnd_latency", lat, 6);
            check_result(etl, etc_, esl, esc);
            release_result($urandom_range(0, 2));
            check_result(etl, etc_, esl, esc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
